eth_rx_pack: RTL and testbench

//  Receive-side companion of the 16-bit-in / 8-bit-out transmit FIFO path.

---
 rtl/eth_rx_pkg.sv | 15 +
 rtl/eth_byte_packer.sv | 37 +++
 rtl/eth_rx_pack.sv | 154 +++++++++++++++
 tb/tb_eth_rx_pack.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared definitions for the GMII receive packer: FSM states and frame constants.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } rx_state_e;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam int unsigned ETH_MAX_BYTES = 1522;

endpackage

// File: rtl/eth_byte_packer.sv
// Pairs payload bytes into 16-bit words: the first byte of a pair is held,
// the second is merged with it. A pad request closes an odd pair with PAD_BYTE.
module eth_byte_packer
    import eth_rx_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,   // start of payload: next byte is a high byte
    input  logic        push_i,    // accept byte_i into the current pair
    input  logic [7:0]  byte_i,
    input  logic        pad_i,     // close the pair with PAD_BYTE instead of byte_i
    output logic        phase_o,   // 1 = high byte held, low byte pending
    output logic [15:0] word_o
);

    logic       phase_q;
    logic [7:0] hold_q;

    // Phase toggles on every accepted byte; the high byte is captured on phase 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            hold_q  <= 8'h00;
        end else if (clear_i) begin
            phase_q <= 1'b0;
        end else if (push_i) begin
            phase_q <= ~phase_q;
            if (!phase_q) hold_q <= byte_i;
        end
    end

    assign phase_o = phase_q;
    assign word_o  = {hold_q, pad_i ? PAD_BYTE : byte_i};

endmodule

// File: rtl/eth_rx_pack.sv
// Receive framer: strips preamble/SFD from a GMII byte burst, packs payload into
// 16-bit FIFO writes and reports length/error/odd status once per frame attempt.
module eth_rx_pack
    import eth_rx_pkg::*;
#(
    parameter int         MAX_BYTES = ETH_MAX_BYTES,
    parameter int         LEN_WIDTH = 11,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_dv,
    input  logic [7:0]           rxd,
    input  logic                 fifo_full,
    output logic                 fifo_we,
    output logic [15:0]          fifo_di,
    output logic                 frame_done,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic                 frame_err,
    output logic                 frame_odd
);

    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_BYTES);
    localparam logic [LEN_WIDTH-1:0] SAT_L = LEN_WIDTH'(MAX_BYTES + 1);

    rx_state_e            st_q, st_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [15:0]          di_q, di_d;
    logic                 done_q, done_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 err_q, err_d;
    logic                 odd_q, odd_d;

    logic                 pk_clear, pk_push, pk_pad, phase;
    logic [15:0]          word;

    eth_byte_packer #(.PAD_BYTE(PAD_BYTE)) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (pk_clear),
        .push_i  (pk_push),
        .byte_i  (rxd),
        .pad_i   (pk_pad),
        .phase_o (phase),
        .word_o  (word)
    );

    // Frame FSM: decides next state, byte count, word writes and end-of-frame status.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        di_d     = di_q;
        done_d   = 1'b0;
        len_d    = '0;
        err_d    = 1'b0;
        odd_d    = 1'b0;
        pk_clear = 1'b0;
        pk_push  = 1'b0;
        pk_pad   = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    cnt_d = '0;
                    st_d  = (rxd == ETH_PREAMBLE) ? ST_PRE : ST_DROP;
                end
            end
            ST_PRE: begin
                if (!rx_dv) begin
                    st_d = ST_IDLE;            // preamble-only noise, nothing reported
                end else if (rxd == ETH_SFD) begin
                    st_d     = ST_DATA;
                    cnt_d    = '0;
                    pk_clear = 1'b1;
                end else if (rxd != ETH_PREAMBLE) begin
                    st_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (rx_dv) begin
                    if (cnt_q == MAX_L) begin
                        // Oversize byte is counted so the length saturates at MAX+1.
                        cnt_d = SAT_L;
                        st_d  = ST_DROP;
                    end else if (phase && fifo_full) begin
                        // Word due but FIFO full: the completing byte is not accepted.
                        st_d = ST_DROP;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        pk_push = 1'b1;
                        if (phase) begin
                            we_d = 1'b1;
                            di_d = word;
                        end
                    end
                end else begin
                    done_d = 1'b1;
                    len_d  = cnt_q;
                    st_d   = ST_IDLE;
                    if (phase) begin
                        pk_pad = 1'b1;
                        if (fifo_full) begin
                            err_d = 1'b1;      // padded tail word could not be written
                        end else begin
                            we_d  = 1'b1;
                            di_d  = word;
                            odd_d = 1'b1;
                        end
                    end
                end
            end
            default: begin                      // ST_DROP
                if (!rx_dv) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    len_d  = cnt_q;
                    st_d   = ST_IDLE;
                end
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            di_q   <= 16'h0000;
            done_q <= 1'b0;
            len_q  <= '0;
            err_q  <= 1'b0;
            odd_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            di_q   <= di_d;
            done_q <= done_d;
            len_q  <= len_d;
            err_q  <= err_d;
            odd_q  <= odd_d;
        end
    end

    assign fifo_we    = we_q;
    assign fifo_di    = di_q;
    assign frame_done = done_q;
    assign frame_len  = len_q;
    assign frame_err  = err_q;
    assign frame_odd  = odd_q;

endmodule

// File: tb/tb_eth_rx_pack.sv
// Randomized bench for eth_rx_pack: each burst is parsed by a byte-level model
// that queues expected FIFO words and frame status; a negedge monitor compares.
module tb_eth_rx_pack;

    localparam int MAXB = 1522;

    typedef struct packed {
        logic [10:0] len;
        logic        err;
        logic        odd;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rxd;
    logic        fifo_full;
    logic        fifo_we;
    logic [15:0] fifo_di;
    logic        frame_done;
    logic [10:0] frame_len;
    logic        frame_err;
    logic        frame_odd;

    always #5 clk = ~clk;

    eth_rx_pack #(.MAX_BYTES(MAXB), .LEN_WIDTH(11), .PAD_BYTE(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_dv      (rx_dv),
        .rxd        (rxd),
        .fifo_full  (fifo_full),
        .fifo_we    (fifo_we),
        .fifo_di    (fifo_di),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .frame_err  (frame_err),
        .frame_odd  (frame_odd)
    );

    int n_pass = 0;
    int n_chk  = 0;

    logic [15:0] exp_wr[$];
    logic [15:0] wr_log[$];
    done_t       exp_dn[$];
    done_t       dn_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Compare every write and every frame_done against the model queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_we) begin
                chk("we_while_full", {31'd0, fifo_full}, 32'd0);
                wr_log.push_back(fifo_di);
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: got %04h expected none", fifo_di);
                end else begin
                    chk("write_data", {16'd0, fifo_di}, {16'd0, exp_wr.pop_front()});
                end
            end
            if (frame_done) begin
                dn_log.push_back({frame_len, frame_err, frame_odd});
                if (exp_dn.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got len=%0d err=%0b odd=%0b expected none",
                             frame_len, frame_err, frame_odd);
                end else begin
                    chk("frame_status", {19'd0, frame_len, frame_err, frame_odd},
                        {19'd0, exp_dn.pop_front()});
                end
            end
        end
    end

    task automatic drive(input bit dv, input logic [7:0] d, input bit full);
        rx_dv     = dv;
        rxd       = d;
        fifo_full = full;
        @(posedge clk);
        #1;
    endtask

    // Model the burst from the frame rules, then drive it. fifo_full is held high
    // from burst index ovf (ovf == size means the rx_dv-low cycle) through rx_dv fall.
    task automatic send_burst(input logic [7:0] b[$], input int ovf, input int tail);
        int n;
        int p;
        int base;
        int nd;
        int len;
        bit err;
        bit odd;
        n = b.size();
        p = 0;
        while (p < n && b[p] == 8'h55) p++;
        if (n > 0 && p < n) begin
            if (p == 0 || b[p] != 8'hD5) begin
                exp_dn.push_back({11'd0, 1'b1, 1'b0});
            end else begin
                base = p + 1;
                nd   = n - base;
                len  = nd;
                err  = 1'b0;
                odd  = 1'b0;
                for (int k = 0; k < nd; k++) begin
                    if (k == MAXB) begin len = MAXB + 1; err = 1'b1; break; end
                    if (k % 2 == 1 && ovf >= 0 && base + k >= ovf) begin len = k; err = 1'b1; break; end
                    if (k % 2 == 1) exp_wr.push_back({b[base+k-1], b[base+k]});
                end
                if (!err && nd % 2 == 1) begin
                    if (ovf >= 0 && n >= ovf) err = 1'b1;
                    else begin exp_wr.push_back({b[n-1], 8'h00}); odd = 1'b1; end
                end
                exp_dn.push_back({11'(len), err, odd});
            end
        end
        for (int i = 0; i < n; i++) drive(1'b1, b[i], ovf >= 0 && i >= ovf);
        drive(1'b0, 8'h00, ovf >= 0 && n >= ovf);
        repeat (tail) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic add_pre(inout logic [7:0] q[$], input int npre);
        for (int i = 0; i < npre; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
    endtask

    initial begin
        logic [7:0] q[$];
        int w0;
        int d0;
        int kind;
        int nd;
        int base;
        int ovf;
        int cands[$];
        logic [7:0] bb;

        rst = 1'b1; rx_dv = 1'b0; rxd = 8'h00; fifo_full = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {1'b0, fifo_we, fifo_di, frame_done, frame_len, frame_err, frame_odd}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        // 1: 64-byte even frame
        w0 = wr_log.size(); d0 = dn_log.size();
        q = {}; add_pre(q, 7);
        for (int i = 0; i < 64; i++) q.push_back(8'(i));
        send_burst(q, -1, 1);
        chk("t1_nwrites", wr_log.size() - w0, 32);
        chk("t1_first", {16'd0, wr_log[w0]}, 32'h0001);
        chk("t1_last", {16'd0, wr_log[w0+31]}, 32'h3E3F);
        chk("t1_status", {19'd0, dn_log[d0]}, {19'd0, 11'd64, 1'b0, 1'b0});

        // 2: odd 3-byte frame, padded tail
        w0 = wr_log.size(); d0 = dn_log.size();
        q = {}; add_pre(q, 7);
        q.push_back(8'hA1); q.push_back(8'hB2); q.push_back(8'hC3);
        send_burst(q, -1, 1);
        chk("t2_word0", {16'd0, wr_log[w0]}, 32'hA1B2);
        chk("t2_word1", {16'd0, wr_log[w0+1]}, 32'hC300);
        chk("t2_status", {19'd0, dn_log[d0]}, {19'd0, 11'd3, 1'b0, 1'b1});

        // 3: FIFO full when the 10th word is due (payload byte index 19)
        w0 = wr_log.size(); d0 = dn_log.size();
        q = {}; add_pre(q, 7);
        for (int i = 0; i < 30; i++) q.push_back(8'(8'h40 + i));
        send_burst(q, 8 + 19, 1);
        chk("t3_nwrites", wr_log.size() - w0, 9);
        chk("t3_status", {19'd0, dn_log[d0]}, {19'd0, 11'd19, 1'b1, 1'b0});

        // 4: oversize frame, length saturates
        w0 = wr_log.size(); d0 = dn_log.size();
        q = {}; add_pre(q, 7);
        for (int i = 0; i < MAXB + 1; i++) q.push_back(8'($urandom));
        send_burst(q, -1, 1);
        chk("t4_nwrites", wr_log.size() - w0, 761);
        chk("t4_status", {19'd0, dn_log[d0]}, {19'd0, 11'd1523, 1'b1, 1'b0});

        // 5: bad preamble byte, then preamble-only noise
        w0 = wr_log.size(); d0 = dn_log.size();
        q = '{8'h55, 8'h55, 8'hAA, 8'h00, 8'h01, 8'h02};
        send_burst(q, -1, 1);
        chk("t5_nwrites", wr_log.size() - w0, 0);
        chk("t5_status", {19'd0, dn_log[d0]}, {19'd0, 11'd0, 1'b1, 1'b0});
        d0 = dn_log.size();
        q = '{8'h55, 8'h55};
        send_burst(q, -1, 2);
        chk("t5_noise_no_done", dn_log.size() - d0, 0);

        // 6: reset after 10 payload bytes abandons the frame
        for (int i = 0; i < 5; i++) exp_wr.push_back({8'(8'h10 + 2*i), 8'(8'h11 + 2*i)});
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
        @(negedge clk);
        #1 rst = 1'b1; rx_dv = 1'b0;
        #1 chk("t6_rst_outputs", {1'b0, fifo_we, fifo_di, frame_done, frame_len, frame_err, frame_odd}, 32'd0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        d0 = dn_log.size();
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        chk("t6_no_done", dn_log.size() - d0, 0);
        w0 = wr_log.size(); d0 = dn_log.size();
        q = {}; add_pre(q, 7);
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04);
        send_burst(q, -1, 1);
        chk("t6_nwrites", wr_log.size() - w0, 2);
        chk("t6_status", {19'd0, dn_log[d0]}, {19'd0, 11'd4, 1'b0, 1'b0});

        // Random bursts, including back-to-back frames (tail 0)
        for (int f = 0; f < 150; f++) begin
            q = {};
            ovf = -1;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                bb = 8'($urandom);
                if (bb == 8'h55) bb = 8'h12;
                q.push_back(bb);
                for (int i = 0; i < $urandom_range(0, 5); i++) q.push_back(8'($urandom));
            end else if (kind == 1) begin
                for (int i = 0; i < $urandom_range(1, 7); i++) q.push_back(8'h55);
            end else if (kind == 2) begin
                for (int i = 0; i < $urandom_range(1, 4); i++) q.push_back(8'h55);
                bb = 8'($urandom);
                if (bb == 8'h55 || bb == 8'hD5) bb = 8'hAA;
                q.push_back(bb);
                for (int i = 0; i < $urandom_range(0, 5); i++) q.push_back(8'($urandom));
            end else begin
                add_pre(q, $urandom_range(1, 7));
                base = q.size();
                nd = $urandom_range(0, 40);
                for (int i = 0; i < nd; i++) q.push_back(8'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    cands = {};
                    for (int k = 1; k < nd; k += 2) cands.push_back(base + k);
                    if (nd % 2 == 1) cands.push_back(base + nd);
                    if (cands.size() > 0) ovf = cands[$urandom_range(0, cands.size() - 1)];
                end
            end
            send_burst(q, ovf, $urandom_range(0, 2));
        end

        repeat (4) drive(1'b0, 8'h00, 1'b0);
        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_dones", exp_dn.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
